demux4_router: RTL
==================

// Module: demux4_router
// PURPOSE
//  1-to-4 registered data router: steers one 32-bit input stream to one of four output channels by SEL.
//  Companion to the 4:1 source-select mux: the mux merges four sources into one, this block fans one
//  producer (e.g. CPU store/IO write path) out to four consumers.
//  Each channel owns a one-entry holding register with valid/ready flow control.
// PARAMETERS
//  WIDTH   32   data width of input and every output channel
//  CNT_W   16   width of per-channel transfer counters (used only with DEMUX_COUNT_EN)
// PORTS
//  CLK        in   1         rising-edge clock; sole clock domain
//  RST        in   1         synchronous, active-high reset
//  IN_DATA    in   WIDTH     input word
//  IN_SEL     in   2         destination channel 0..3; sampled with IN_DATA
//  IN_VALID   in   1         producer offers IN_DATA/IN_SEL
//  IN_READY   out  1         router accepts this cycle (IN_VALID & IN_READY = transfer)
//  OUT_DATA   out  4xWIDTH   per-channel data, packed [3:0][WIDTH-1:0]
//  OUT_VALID  out  4         per-channel valid
//  OUT_READY  in   4         per-channel consumer ready
//  XFER_CNT   out  4xCNT_W   per-channel completed-output counters (present only with DEMUX_COUNT_EN)
// BEHAVIOUR
//  - Reset (RST=1 at edge): all channels EMPTY; OUT_VALID=0, OUT_DATA=0, XFER_CNT=0; IN_READY=0 while RST=1.
//  - Per-channel state: EMPTY / FULL. EMPTY->FULL on accept to that channel; FULL->EMPTY on OUT_VALID&OUT_READY
//    with no same-cycle accept; FULL->FULL when drain and accept coincide (register reloads with new word).
//  - IN_READY = !RST & (!full[IN_SEL] | OUT_READY[IN_SEL]); combinational from IN_SEL and OUT_READY.
//  - Latency: word accepted at edge N appears on OUT_DATA[IN_SEL] with OUT_VALID=1 after edge N (1 cycle).
//  - Throughput: 1 word/cycle sustained to any channel whose consumer holds OUT_READY=1.
//  - Only the selected channel is affected by an accept; other channels keep state and data unchanged.
//  - OUT_DATA[i] holds last loaded value while EMPTY (not cleared on drain); only reset clears it.
//  - OUT_VALID/OUT_DATA are registered; no combinational IN_*->OUT_* path.
//  - Full selected channel + OUT_READY=0: IN_READY=0, producer must hold IN_DATA/IN_SEL stable (no drop).
//  - Backpressure on one channel does not block other channels once producer changes IN_SEL.
//  - Simultaneous drains on multiple channels are independent, all in the same cycle.
//  - Reset mid-operation discards buffered words; no output valid asserted in the cycle after reset.
// CONFIGURATION
//  - Macro DEMUX_COUNT_EN defined: XFER_CNT port present; counter i increments by 1 on each
//    OUT_VALID[i]&OUT_READY[i]; wraps 2^CNT_W-1 -> 0; cleared by RST.
//  - Undefined: XFER_CNT port and counters omitted; all other behaviour identical.
// STRUCTURE
//  - Package demux_pkg: NUM_CH=4; typedef logic [1:0] chan_sel_t; typedef enum logic {CH_EMPTY, CH_FULL} chan_st_t.
//  - Sub-module demux_chan_buf: one-entry valid/ready register (+ optional counter), instantiated 4x
//    via generate; top contains only SEL decode and IN_READY mux.
// TESTING
//  - Reset: RST=1 two cycles -> OUT_VALID=4'b0000, OUT_DATA all 0, IN_READY=0; XFER_CNT=0 with macro.
//  - Basic route: OUT_READY=4'hF, send 0xDEAD_BEEF SEL=2 -> next cycle OUT_VALID=4'b0100, OUT_DATA[2]=0xDEAD_BEEF.
//  - Backpressure: OUT_READY[1]=0, send 0x11 SEL=1 then 0x22 SEL=1 -> IN_READY=0 on 2nd; OUT_DATA[1]=0x11
//    held; raise OUT_READY[1] -> 0x22 accepted same cycle, appears next cycle, no word lost.
//  - Independence: ch0 stalled FULL with 0xA; send 0xB SEL=3 -> accepted, OUT_DATA[3]=0xB, ch0 still 0xA.
//  - Streaming: OUT_READY[0]=1, 8 back-to-back words 1..8 SEL=0 -> IN_READY stays 1, outputs 1..8 in order,
//    one per cycle; with macro XFER_CNT[0]=8.
//  - Reset mid-stream: ch2 FULL with 0x55, assert RST -> OUT_VALID[2]=0 next cycle; counter wrap with CNT_W=4:
//    16 transfers on ch0 -> XFER_CNT[0]=0.

Source files
------------

// File: rtl/demux4_router_pkg.sv
// demux_pkg: shared channel count, select type and per-channel state encoding for demux4_router
package demux_pkg;
  localparam int NUM_CH = 4;
  typedef logic [1:0] chan_sel_t;
  typedef enum logic {CH_EMPTY, CH_FULL} chan_st_t;
endpackage

// File: rtl/demux_chan_buf.sv
// demux_chan_buf: one-entry valid/ready holding register; DEMUX_COUNT_EN adds a completed-output counter
module demux_chan_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);
  chan_st_t st, st_nxt;
  always_ff @(posedge clk) begin
    st <= rst ? CH_EMPTY : st_nxt;
    if (rst) out_data <= '0;
    else if (load) out_data <= in_data;
  end
  always_comb begin
    st_nxt = st;
    st_nxt = load ? CH_FULL : (st == CH_FULL && out_ready) ? CH_EMPTY : st;
  end
  assign out_valid = st == CH_FULL;
`ifdef DEMUX_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (out_valid && out_ready) cnt <= cnt + 1'b1;
  end
`endif
endmodule

// File: rtl/demux4_router.sv
// demux4_router: 1-to-4 registered valid/ready router steering one stream by in_sel;
// DEMUX_COUNT_EN adds the per-channel xfer_cnt counters
module demux4_router
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              in_data,
  input  chan_sel_t                     in_sel,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_CH-1:0][WIDTH-1:0]  out_data,
  output logic [NUM_CH-1:0]             out_valid,
  input  logic [NUM_CH-1:0]             out_ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [NUM_CH-1:0][CNT_W-1:0]  xfer_cnt
`endif
);
  logic accept;
  assign in_ready = !rst && (!out_valid[in_sel] || out_ready[in_sel]);
  assign accept = in_valid && in_ready;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    demux_chan_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_buf (
      .clk(clk),
      .rst(rst),
      .load(accept && in_sel == chan_sel_t'(i)),
      .in_data(in_data),
      .out_ready(out_ready[i]),
      .out_data(out_data[i]),
      .out_valid(out_valid[i])
`ifdef DEMUX_COUNT_EN
      ,
      .cnt(xfer_cnt[i])
`endif
    );
  end
endmodule
